rice_encoder: RTL and testbench

//  Entropy-codes the residue block written by the LPC inverse filter into a packed MSB-first bitstream.

---
 rtl/lpc_pkg.sv | 19 +
 rtl/rice_code_gen.sv | 31 +++
 rtl/rice_encoder.sv | 131 +++++++++++++
 tb/tb_rice_encoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared constants and FSM state type for the LPC residue coding path.
package lpc_pkg;

    localparam int unsigned N_SAMPLES = 256;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ESC_Q     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCode,
        StEmit,
        StFlush,
        StDone
    } rice_state_t;

endpackage

// File: rtl/rice_code_gen.sv
// Combinational zigzag map plus Rice/escape code former; code is right-aligned in 32 bits.
module rice_code_gen
    import lpc_pkg::*;
(
    input  logic [DATA_W-1:0] residue,
    input  logic [3:0]        k,
    output logic [31:0]       code,
    output logic [5:0]        len
);

    logic [15:0] u;
    logic [15:0] q;
    logic [31:0] ones;
    logic [31:0] low;

    always_comb begin
        u    = {residue[14:0], 1'b0} ^ {16{residue[15]}};
        q    = u >> k;
        ones = ((32'd1 << q[3:0]) - 32'd1) << ({1'b0, k} + 5'd1);
        low  = {16'd0, u} & ((32'd1 << k) - 32'd1);
        if (q >= 16'(ESC_Q)) begin
            // Escape: ESC_Q ones followed by the raw mapped value
            code = {16'hFFFF, u};
            len  = 6'd32;
        end else begin
            code = ones | low;
            len  = {2'b00, q[3:0]} + 6'd1 + {2'b00, k};
        end
    end

endmodule

// File: rtl/rice_encoder.sv
// Reads a residue frame, Rice-codes each sample and packs codes MSB-first into 32-bit words.
module rice_encoder
    import lpc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        rice_k,
    output logic              ready,
    output logic [ADDR_W-1:0] residue_raddr,
    input  logic [DATA_W-1:0] residue_r,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [13:0]       bit_count
);

    rice_state_t       state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [63:0]       buf_q, buf_d;
    logic [6:0]        fill_q, fill_d;
    logic [13:0]       bits_q, bits_d;

    logic [31:0] code;
    logic [5:0]  len;
    logic        last_sample;
    logic [63:0] appended;
    logic [6:0]  fill_app;
    logic [6:0]  fill_rem;

    rice_code_gen u_code_gen (
        .residue (residue_r),
        .k       (k_q),
        .code    (code),
        .len     (len)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            raddr_q <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            raddr_q <= raddr_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            bits_q  <= bits_d;
        end
    end

    always_comb begin
        last_sample = (raddr_q == ADDR_W'(N_SAMPLES - 1));
        // fill < 32 whenever a code is appended, so the shift never goes negative
        appended    = buf_q | ({32'd0, code} << (7'd64 - fill_q - {1'b0, len}));
        fill_app    = fill_q + {1'b0, len};
        fill_rem    = fill_q - 7'd32;

        state_d = state_q;
        k_d     = k_q;
        raddr_d = raddr_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        bits_d  = bits_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = rice_k;
                    raddr_d = '0;
                    bits_d  = '0;
                    buf_d   = '0;
                    fill_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StCode;
            StCode: begin
                buf_d  = appended;
                fill_d = fill_app;
                bits_d = bits_q + 14'(len);
                if (fill_app >= 7'd32) begin
                    state_d = StEmit;
                end else if (last_sample) begin
                    state_d = (fill_app != 7'd0) ? StFlush : StDone;
                end else begin
                    raddr_d = raddr_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    buf_d  = buf_q << 32;
                    fill_d = fill_rem;
                    if (last_sample) begin
                        state_d = (fill_rem != 7'd0) ? StFlush : StDone;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StFlush: begin
                if (out_ready) begin
                    buf_d   = '0;
                    fill_d  = '0;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready         = (state_q == StIdle);
        out_valid     = (state_q == StEmit) || (state_q == StFlush);
        out_data      = buf_q[63:32];
        out_last      = ((state_q == StEmit) && last_sample && (fill_rem == 7'd0)) ||
                        (state_q == StFlush);
        residue_raddr = raddr_q;
        bit_count     = bits_q;
    end

endmodule

// File: tb/tb_rice_encoder.sv
// Directed table-driven bench for rice_encoder with a synchronous RAM model and word collector.
module tb_rice_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rice_k = 4'd0;
    logic        ready;
    logic [7:0]  residue_raddr;
    logic [15:0] residue_r;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [13:0] bit_count;

    logic [15:0] mem [256];
    logic [31:0] words[$];
    logic        lasts[$];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] r0, r1, r2, rest;
        logic [3:0]  k;
        int          nwords;
        logic [31:0] first;
        logic [31:0] body;
        int          bits;
    } vec_t;

    vec_t tbl[7];

    rice_encoder dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rice_k        (rice_k),
        .ready         (ready),
        .residue_raddr (residue_raddr),
        .residue_r     (residue_r),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) residue_r <= mem[residue_raddr];

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            words.push_back(out_data);
            lasts.push_back(out_last);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = v.rest;
        mem[0] = v.r0;
        mem[1] = v.r1;
        mem[2] = v.r2;
    endtask

    task automatic pulse_start(input logic [3:0] k);
        @(posedge clk); #1;
        rice_k = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!ready && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        if (!ready) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input vec_t v);
        int bad = 0;
        int nl = 0;
        int lastidx = -1;
        chk("nwords", words.size(), v.nwords);
        chk("first_word", (words.size() > 0) ? words[0] : 32'hDEADBEEF, v.first);
        for (int i = 1; i < words.size(); i++) if (words[i] !== v.body) bad++;
        chk("body_words_bad", bad, 0);
        foreach (lasts[i]) if (lasts[i]) begin nl++; lastidx = i; end
        chk("last_count", nl, 1);
        chk("last_pos", lastidx, v.nwords - 1);
        chk("bit_count", {18'd0, bit_count}, v.bits);
    endtask

    task automatic run_frame(input vec_t v, input int stall);
        logic [31:0] d0;
        logic [7:0]  a0;
        int cyc = 0;
        load(v);
        words.delete();
        lasts.delete();
        out_ready = (stall == 0);
        pulse_start(v.k);
        chk("ready_low", {31'd0, ready}, 32'd0);
        if (stall > 0) begin
            while (!out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("stall_reach_emit", {31'd0, out_valid}, 32'd1);
            d0 = out_data;
            a0 = residue_raddr;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                start = (i == 1);  // stray start while busy must be ignored
                @(negedge clk);
                chk("stall_data", out_data, d0);
                chk("stall_addr", {24'd0, residue_raddr}, {24'd0, a0});
            end
            @(posedge clk); #1;
            start     = 1'b0;
            out_ready = 1'b1;
        end
        wait_done();
        check_frame(v);
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0,   8, 32'h00000000,
                   32'h00000000,  256};
        tbl[1] = '{16'h0001, 16'hFFFF, 16'h0002, 16'h0000, 4'd0,   9, 32'hD7800000,
                   32'h00000000,  263};
        tbl[2] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 4'd0,   9, 32'hFFFFFFFE,
                   32'h00000000,  287};
        tbl[3] = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD, 4'd2,  32, 32'h99999999,
                   32'h99999999, 1024};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd15, 128, 32'h00000000,
                   32'h00000000, 4096};
        tbl[5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'd3,  32, 32'h22222222,
                   32'h22222222, 1024};
        tbl[6] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'd0, 256, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 8192};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_raddr", {24'd0, residue_raddr}, 32'd0);
        chk("rst_bits", {18'd0, bit_count}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) run_frame(tbl[v], 0);

        // Backpressure at the first word, with a stray start during the stall
        run_frame(tbl[3], 5);

        // Reset while coding sample 100, then a clean frame
        begin
            int cyc = 0;
            load(tbl[3]);
            words.delete();
            lasts.delete();
            out_ready = 1'b1;
            pulse_start(tbl[3].k);
            while (residue_raddr != 8'd100 && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            chk("reach_sample100", {24'd0, residue_raddr}, 32'd100);
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk("midrst_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_ready", {31'd0, ready}, 32'd1);
            chk("midrst_raddr", {24'd0, residue_raddr}, 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            chk("midrst_valid_hold", {31'd0, out_valid}, 32'd0);
        end
        run_frame(tbl[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
